// File: rtl/axi_read_arbiter.sv
// Two-requester AXI-Lite read arbiter sharing one slave, round-robin, one transaction in flight.
// Optional read watchdog enabled by defining ARB_READ_TIMEOUT_EN.
module axi_read_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int RESP_WIDTH     = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  axi_aclk,
  input  logic                  axi_areset,
  input  logic [ADDR_WIDTH-1:0] s0_axi_araddr,
  input  logic                  s0_axi_arvalid,
  output logic                  s0_axi_arready,
  output logic [DATA_WIDTH-1:0] s0_axi_rdata,
  output logic [RESP_WIDTH-1:0] s0_axi_rresp,
  output logic                  s0_axi_rvalid,
  input  logic                  s0_axi_rready,
  input  logic [ADDR_WIDTH-1:0] s1_axi_araddr,
  input  logic                  s1_axi_arvalid,
  output logic                  s1_axi_arready,
  output logic [DATA_WIDTH-1:0] s1_axi_rdata,
  output logic [RESP_WIDTH-1:0] s1_axi_rresp,
  output logic                  s1_axi_rvalid,
  input  logic                  s1_axi_rready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [RESP_WIDTH-1:0] m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                state;
  logic                  gnt, ptr, win, done, g_rready, r_valid;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] r_data;
  logic [RESP_WIDTH-1:0] r_resp;

`ifdef ARB_READ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tcnt;
  logic          tout;
`else
  logic tout, unused_timeout;
  assign tout           = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  // A lone requester wins outright; the pointer only breaks ties.
  assign win      = (s0_axi_arvalid && s1_axi_arvalid) ? ptr : s1_axi_arvalid;
  assign g_rready = gnt ? s1_axi_rready : s0_axi_rready;

  assign s0_axi_arready = (state == IDLE) && !axi_areset && s0_axi_arvalid && !win;
  assign s1_axi_arready = (state == IDLE) && !axi_areset && s1_axi_arvalid && win;
  assign m_axi_arvalid  = (state == ADDR);
  assign m_axi_araddr   = addr_q;

  always_comb begin
    r_valid      = 1'b0;
    r_data       = '0;
    r_resp       = '0;
    m_axi_rready = 1'b0;
    done         = 1'b0;
    if (state == DATA) begin
      if (tout) begin
        r_valid      = 1'b1;
        r_resp       = RESP_WIDTH'(2);
        m_axi_rready = 1'b1;
        done         = g_rready;
      end else begin
        r_valid      = m_axi_rvalid;
        r_data       = m_axi_rdata;
        r_resp       = m_axi_rresp;
        m_axi_rready = g_rready;
        done         = m_axi_rvalid && g_rready;
      end
    end
`ifdef ARB_READ_TIMEOUT_EN
    // Keep draining so a late response to an abandoned read cannot stick.
    else if (state == IDLE) m_axi_rready = 1'b1;
`endif
  end

  assign s0_axi_rvalid = r_valid && !gnt;
  assign s1_axi_rvalid = r_valid && gnt;
  assign s0_axi_rdata  = gnt ? '0 : r_data;
  assign s1_axi_rdata  = gnt ? r_data : '0;
  assign s0_axi_rresp  = gnt ? '0 : r_resp;
  assign s1_axi_rresp  = gnt ? r_resp : '0;

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state  <= IDLE;
      gnt    <= 1'b0;
      ptr    <= 1'b0;
      addr_q <= '0;
`ifdef ARB_READ_TIMEOUT_EN
      tcnt   <= '0;
      tout   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (s0_axi_arvalid || s1_axi_arvalid) begin
          gnt    <= win;
          addr_q <= win ? s1_axi_araddr : s0_axi_araddr;
          state  <= ADDR;
        end
        ADDR: if (m_axi_arready) begin
          state <= DATA;
`ifdef ARB_READ_TIMEOUT_EN
          tcnt  <= '0;
          tout  <= 1'b0;
`endif
        end
        DATA: begin
          if (done) begin
            state <= IDLE;
            ptr   <= ~gnt;
          end
`ifdef ARB_READ_TIMEOUT_EN
          else if (!tout && !m_axi_rvalid) begin
            if (tcnt == CW'(TIMEOUT_CYCLES - 1)) tout <= 1'b1;
            else tcnt <= tcnt + CW'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_read_arbiter.md
AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, read data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, address width.
REQ-003 SHALL have parameter RESP_WIDTH, default 2, response width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16, watchdog limit (used only under REQ-026).
REQ-005 SHALL have port axi_aclk, input, 1, sole clock; all logic rises on posedge.
REQ-006 SHALL have port axi_areset, input, 1, reset, synchronous, active-high.
REQ-007 SHALL have ports s0_axi_araddr / s1_axi_araddr, input, ADDR_WIDTH, requester read address.
REQ-008 SHALL have ports s0_axi_arvalid / s1_axi_arvalid, input, 1, requester address valid.
REQ-009 SHALL have ports s0_axi_arready / s1_axi_arready, output, 1, address accepted.
REQ-010 SHALL have ports s0_axi_rdata / s1_axi_rdata, output, DATA_WIDTH, read data to requester.
REQ-011 SHALL have ports s0_axi_rresp / s1_axi_rresp, output, RESP_WIDTH, read response to requester.
REQ-012 SHALL have ports s0_axi_rvalid / s1_axi_rvalid (output, 1) and s0_axi_rready / s1_axi_rready (input, 1), requester data handshake.
REQ-013 SHALL have ports m_axi_araddr (output, ADDR_WIDTH), m_axi_arvalid (output, 1), m_axi_arready (input, 1), shared-slave address channel.
REQ-014 SHALL have ports m_axi_rdata (input, DATA_WIDTH), m_axi_rresp (input, RESP_WIDTH), m_axi_rvalid (input, 1), m_axi_rready (output, 1), shared-slave data channel.

Function
REQ-015 SHALL share one AXI-Lite read slave between two requesters, one outstanding transaction total.
REQ-016 SHALL implement FSM states IDLE, ADDR, DATA.
REQ-017 IDLE: if any sN_axi_arvalid, winner gets sN_axi_arready=1 combinationally that cycle, araddr and grant index registered, next state ADDR; else stay IDLE.
REQ-018 Both arvalid in same cycle: winner is requester indicated by priority pointer; loser's arready stays 0.
REQ-019 Priority pointer SHALL point at the non-granted requester after every completed transaction (round-robin); single requester always wins regardless of pointer.
REQ-020 ADDR: m_axi_arvalid=1, m_axi_araddr=latched address, held stable until m_axi_arready; then DATA.
REQ-021 DATA: m_axi_rready = granted sN_axi_rready; granted sN_axi_rvalid/rdata/rresp = m_axi_rvalid/rdata/rresp combinationally; non-granted rvalid=0.
REQ-022 DATA: on m_axi_rvalid && m_axi_rready, next state IDLE and pointer updates; new grant earliest the following cycle.
REQ-023 arready SHALL be 0 for both requesters outside IDLE; m_axi_arvalid 0 outside ADDR; m_axi_rready 0 outside DATA (except REQ-026).
REQ-024 Minimum latency: accept at cycle N, m_axi_arvalid at N+1, requester data at earliest N+2 with zero-wait slave.

Reset
REQ-025 axi_areset high at any clock edge, including mid-transaction, SHALL force IDLE, pointer to s0, all valid/ready outputs 0, data/resp outputs 0; in-flight transaction is abandoned.

Configuration
REQ-026 Macro ARB_READ_TIMEOUT_EN defined: counter runs in DATA; after TIMEOUT_CYCLES cycles with no m_axi_rvalid, granted requester receives rvalid=1, rresp=2 (SLVERR), rdata=0, held until its rready, then IDLE; m_axi_rready held 1 in IDLE to drain a late slave response, which is discarded. Undefined: no counter, DATA waits indefinitely, m_axi_rready 0 in IDLE.

Verification
REQ-027 s0 alone reads 0x08, slave returns 0xDEADBEEF resp 0 after 1 cycle -> s0 gets rdata 0xDEADBEEF resp 0, s1_axi_rvalid stays 0.
REQ-028 s0 and s1 arvalid same cycle after reset (s0 addr 0x08, s1 addr 0x18) -> s0 granted first, m_axi_araddr 0x08 then 0x18, s1 served second.
REQ-029 Both requesters continuously valid for 4 transactions -> grant order s0, s1, s0, s1.
REQ-030 m_axi_arready low 5 cycles -> m_axi_arvalid held 1 and m_axi_araddr stable all 5 cycles; s1_axi_rready low 3 cycles in DATA -> m_axi_rready low same 3 cycles.
REQ-031 axi_areset asserted in DATA -> next cycle IDLE, all valid/ready 0; next request from s1 alone granted normally.
REQ-032 With ARB_READ_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never asserts rvalid -> requester gets rresp 2, rdata 0 after 16 DATA cycles; without macro, rvalid stays 0.
